// File: rtl/tie_strap_pkg.sv
// Shared types and helpers for the programmable tie-off strap controller.
package tie_strap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        COMMIT,
        DONE,
        LOCKED
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tie_strap_shreg.sv
// Shadow shift register: parallel load from the live straps, serial shift-in
// at the LSB, MSB exposed for serial readback.
module tie_strap_shreg
    import tie_strap_pkg::*;
#(
    parameter int unsigned    N       = 8,
    parameter logic [N-1:0]   DEFAULT = '0
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         shift_en,
    input  logic         sdi,
    output logic [N-1:0] q,
    output logic         msb
);

    logic [N-1:0] shifted;

    // A one-bit register has no lower bits to carry along.
    generate
        if (N == 1) begin : g_single
            assign shifted = sdi;
        end else begin : g_multi
            assign shifted = {q[N-2:0], sdi};
        end
    endgenerate

    always_ff @(posedge ck) begin
        if (rst) begin
            q <= DEFAULT;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= shifted;
        end
    end

    assign msb = q[N-1];

endmodule

// File: rtl/tie_strap_ctrl.sv
// Programmable tie-off bank: registered straps reset to DEFAULT, atomically
// rewritten by a serial programming handshake, optionally locked until reset.
module tie_strap_ctrl
    import tie_strap_pkg::*;
#(
    parameter int unsigned  N       = 8,
    parameter logic [N-1:0] DEFAULT = N'(8'hA5)
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         prog_req,
    input  logic         sdi,
    input  logic         sdi_vld,
    input  logic         lock,
    output logic         prog_ack,
    output logic         busy,
    output logic         sdo,
    output logic         err,
    output logic         locked,
    output logic [N-1:0] strap
);

    localparam int unsigned    CW       = cnt_w(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(N);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          req_q;
    logic          err_q;
    logic [N-1:0]  shadow;
    logic          shadow_msb;
    logic          load, shift_en, commit, err_nxt;

    tie_strap_shreg #(
        .N       (N),
        .DEFAULT (DEFAULT)
    ) u_shreg (
        .ck       (ck),
        .rst      (rst),
        .load     (load),
        .load_val (strap),
        .shift_en (shift_en),
        .sdi      (sdi),
        .q        (shadow),
        .msb      (shadow_msb)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        commit    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (prog_req) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                // Dropping the request wins over a simultaneous final bit.
                if (!prog_req) begin
                    err_nxt   = 1'b1;
                    load      = 1'b1;
                    state_nxt = IDLE;
                end else if (sdi_vld) begin
                    shift_en = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = lock ? LOCKED : DONE;
            end
            DONE: begin
                if (!prog_req) begin
                    state_nxt = IDLE;
                end
            end
            LOCKED: begin
                err_nxt = prog_req & ~req_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state <= IDLE;
            strap <= DEFAULT;
            cnt   <= '0;
            req_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            req_q <= prog_req;
            err_q <= err_nxt;
            if (commit) begin
                strap <= shadow;
            end
            if (load) begin
                cnt <= '0;
            end else if (shift_en && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy     = (state == SHIFT) || (state == COMMIT);
    assign prog_ack = (state == COMMIT);
    assign locked   = (state == LOCKED);
    assign err      = err_q;
    // Readback is only meaningful while shifting; otherwise hold low.
    assign sdo      = (state == SHIFT) && shadow_msb;

endmodule

// File: tb/tb_tie_strap_ctrl.sv
// Self-checking bench for tie_strap_ctrl at N=8, N=1 and N=64.
module tb_tie_strap_ctrl;

    logic ck, rst, prog_req, sdi, sdi_vld, lock;

    logic       a_prog_ack, a_busy, a_sdo, a_err, a_locked;
    logic [7:0] a_strap;
    logic       b_prog_ack, b_busy, b_sdo, b_err, b_locked;
    logic [0:0] b_strap;
    logic        c_prog_ack, c_busy, c_sdo, c_err, c_locked;
    logic [63:0] c_strap;

    localparam logic [7:0]  DEF8  = 8'hA5;
    localparam logic [0:0]  DEF1  = 1'b0;
    localparam logic [63:0] DEF64 = 64'hFEDC_BA98_7654_3210;

    int n_checks = 0;
    int n_fail   = 0;

    bit sdo_exp[$];
    bit sdo_obs[$];

    tie_strap_ctrl #(.N(8), .DEFAULT(DEF8)) dut8 (
        .ck(ck), .rst(rst), .prog_req(prog_req), .sdi(sdi), .sdi_vld(sdi_vld), .lock(lock),
        .prog_ack(a_prog_ack), .busy(a_busy), .sdo(a_sdo), .err(a_err), .locked(a_locked),
        .strap(a_strap)
    );

    tie_strap_ctrl #(.N(1), .DEFAULT(DEF1)) dut1 (
        .ck(ck), .rst(rst), .prog_req(prog_req), .sdi(sdi), .sdi_vld(sdi_vld), .lock(lock),
        .prog_ack(b_prog_ack), .busy(b_busy), .sdo(b_sdo), .err(b_err), .locked(b_locked),
        .strap(b_strap)
    );

    tie_strap_ctrl #(.N(64), .DEFAULT(DEF64)) dut64 (
        .ck(ck), .rst(rst), .prog_req(prog_req), .sdi(sdi), .sdi_vld(sdi_vld), .lock(lock),
        .prog_ack(c_prog_ack), .busy(c_busy), .sdo(c_sdo), .err(c_err), .locked(c_locked),
        .strap(c_strap)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic start_req();
        prog_req = 1'b1;
        step();
    endtask

    // Drives nbits of data MSB first into the N=8 instance; queues the old
    // strap bit expected on sdo and the sdo actually seen in each valid cycle.
    task automatic send8(input logic [7:0] data, input logic [7:0] old,
                         input int nbits, input bit gap);
        for (int i = 0; i < nbits; i++) begin
            sdi_vld = 1'b1;
            sdi     = data[7-i];
            sdo_exp.push_back(old[7-i]);
            sdo_obs.push_back(a_sdo);
            step();
            sdi_vld = 1'b0;
            if (gap && i != nbits - 1) step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (a_strap !== DEF8) begin n_fail++; $display("FAIL reset_strap: got %h exp %h", a_strap, DEF8); end
        n_checks++;
        if ({a_locked, a_busy, a_prog_ack, a_err, a_sdo} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b exp 00000", {a_locked, a_busy, a_prog_ack, a_err, a_sdo});
        end
        n_checks++;
        if ({b_strap, b_locked, b_busy, b_prog_ack, b_err, b_sdo} !== 6'b0) begin
            n_fail++; $display("FAIL reset_n1: got %b exp 000000", {b_strap, b_locked, b_busy, b_prog_ack, b_err, b_sdo});
        end
        n_checks++;
        if (c_strap !== DEF64 || {c_locked, c_busy, c_prog_ack, c_err, c_sdo} !== 5'b0) begin
            n_fail++; $display("FAIL reset_n64: got %h/%b exp %h/00000", c_strap,
                               {c_locked, c_busy, c_prog_ack, c_err, c_sdo}, DEF64);
        end
        rst = 1'b0;
    endtask

    task automatic test_program();
        bit e, o;
        int acks;
        start_req();
        n_checks++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL prog_busy: got %b exp 1", a_busy); end
        send8(8'h3C, DEF8, 8, 1'b1);
        n_checks++;
        if (a_prog_ack !== 1'b1 || a_strap !== DEF8) begin
            n_fail++; $display("FAIL prog_commit: ack %b strap %h exp ack 1 strap %h", a_prog_ack, a_strap, DEF8);
        end
        step();
        n_checks++;
        if (a_strap !== 8'h3C || a_prog_ack !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL prog_strap: strap %h ack %b busy %b exp 3c 0 0", a_strap, a_prog_ack, a_busy);
        end
        while (sdo_exp.size() != 0) begin
            e = sdo_exp.pop_front();
            o = sdo_obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL prog_sdo: got %b exp %b", o, e); end
        end
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (a_prog_ack || a_busy) acks++;
        end
        n_checks++;
        if (acks != 0 || a_strap !== 8'h3C) begin
            n_fail++; $display("FAIL prog_retrigger: activity %0d strap %h exp 0 3c", acks, a_strap);
        end
        prog_req = 1'b0;
        step();
        prog_req = 1'b1;
        step();
        n_checks++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL prog_rearm: busy %b exp 1", a_busy); end
        prog_req = 1'b0;
        step();
        n_checks++;
        if (a_err !== 1'b1 || a_strap !== 8'h3C) begin
            n_fail++; $display("FAIL prog_empty_abort: err %b strap %h exp 1 3c", a_err, a_strap);
        end
        step();
    endtask

    task automatic test_abort();
        bit e, o;
        pulse_rst();
        start_req();
        send8(8'h0F, DEF8, 5, 1'b0);
        prog_req = 1'b0;
        step();
        n_checks++;
        if (a_err !== 1'b1 || a_busy !== 1'b0 || a_strap !== DEF8) begin
            n_fail++; $display("FAIL abort5: err %b busy %b strap %h exp 1 0 %h", a_err, a_busy, a_strap, DEF8);
        end
        step();
        n_checks++;
        if (a_err !== 1'b0 || a_strap !== DEF8) begin
            n_fail++; $display("FAIL abort5_after: err %b strap %h exp 0 %h", a_err, a_strap, DEF8);
        end
        start_req();
        send8(8'h42, DEF8, 7, 1'b0);
        prog_req = 1'b0;
        sdi_vld  = 1'b1;
        sdi      = 1'b1;
        step();
        sdi_vld  = 1'b0;
        n_checks++;
        if (a_err !== 1'b1 || a_prog_ack !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL abort8: err %b ack %b busy %b exp 1 0 0", a_err, a_prog_ack, a_busy);
        end
        step();
        n_checks++;
        if (a_strap !== DEF8 || a_prog_ack !== 1'b0) begin
            n_fail++; $display("FAIL abort8_strap: strap %h ack %b exp %h 0", a_strap, a_prog_ack, DEF8);
        end
        while (sdo_exp.size() != 0) begin
            e = sdo_exp.pop_front();
            o = sdo_obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL abort_sdo: got %b exp %b", o, e); end
        end
    endtask

    task automatic test_lock();
        bit e, o;
        int errs;
        lock = 1'b1;
        start_req();
        send8(8'hFF, DEF8, 8, 1'b0);
        step();
        lock = 1'b0;
        n_checks++;
        if (a_strap !== 8'hFF || a_locked !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL lock_enter: strap %h locked %b busy %b exp ff 1 0", a_strap, a_locked, a_busy);
        end
        step();
        n_checks++;
        if (a_err !== 1'b0) begin n_fail++; $display("FAIL lock_held_req: err %b exp 0", a_err); end
        prog_req = 1'b0;
        step();
        errs = 0;
        for (int p = 0; p < 2; p++) begin
            prog_req = 1'b1;
            step();
            if (a_err) errs++;
            step();
            if (a_err) errs++;
            prog_req = 1'b0;
            step();
            if (a_err) errs++;
        end
        n_checks++;
        if (errs != 2) begin n_fail++; $display("FAIL lock_err_pulses: got %0d exp 2", errs); end
        n_checks++;
        if (a_strap !== 8'hFF || a_locked !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL lock_frozen: strap %h locked %b busy %b exp ff 1 0", a_strap, a_locked, a_busy);
        end
        pulse_rst();
        n_checks++;
        if (a_strap !== DEF8 || a_locked !== 1'b0) begin
            n_fail++; $display("FAIL lock_reset: strap %h locked %b exp %h 0", a_strap, a_locked, DEF8);
        end
        while (sdo_exp.size() != 0) begin
            e = sdo_exp.pop_front();
            o = sdo_obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL lock_sdo: got %b exp %b", o, e); end
        end
    endtask

    task automatic test_reset_mid_shift();
        bit e, o;
        start_req();
        send8(8'h99, DEF8, 3, 1'b0);
        rst      = 1'b1;
        prog_req = 1'b0;
        step();
        rst = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0 || a_strap !== DEF8 || a_sdo !== 1'b0 || a_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst: busy %b strap %h sdo %b err %b exp 0 %h 0 0",
                               a_busy, a_strap, a_sdo, a_err, DEF8);
        end
        start_req();
        send8(8'h5A, DEF8, 8, 1'b0);
        step();
        n_checks++;
        if (a_strap !== 8'h5A) begin n_fail++; $display("FAIL midrst_retry: strap %h exp 5a", a_strap); end
        prog_req = 1'b0;
        step();
        while (sdo_exp.size() != 0) begin
            e = sdo_exp.pop_front();
            o = sdo_obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL midrst_sdo: got %b exp %b", o, e); end
        end
    endtask

    task automatic test_n1();
        pulse_rst();
        start_req();
        n_checks++;
        if (b_busy !== 1'b1 || b_sdo !== DEF1[0]) begin
            n_fail++; $display("FAIL n1_shift: busy %b sdo %b exp 1 %b", b_busy, b_sdo, DEF1[0]);
        end
        sdi_vld = 1'b1;
        sdi     = 1'b1;
        step();
        sdi_vld = 1'b0;
        n_checks++;
        if (b_prog_ack !== 1'b1 || b_strap !== DEF1) begin
            n_fail++; $display("FAIL n1_commit: ack %b strap %b exp 1 %b", b_prog_ack, b_strap, DEF1);
        end
        step();
        n_checks++;
        if (b_strap !== 1'b1 || b_prog_ack !== 1'b0) begin
            n_fail++; $display("FAIL n1_strap: strap %b ack %b exp 1 0", b_strap, b_prog_ack);
        end
        prog_req = 1'b0;
        step();
        start_req();
        n_checks++;
        if (b_sdo !== 1'b1) begin n_fail++; $display("FAIL n1_readback: sdo %b exp 1", b_sdo); end
        prog_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_n64();
        bit e, o;
        logic [63:0] data;
        data = {$urandom(), $urandom()};
        pulse_rst();
        start_req();
        for (int i = 0; i < 64; i++) begin
            sdi_vld = 1'b1;
            sdi     = data[63-i];
            sdo_exp.push_back(DEF64[63-i]);
            sdo_obs.push_back(c_sdo);
            step();
        end
        n_checks++;
        if (c_prog_ack !== 1'b1 || c_strap !== DEF64) begin
            n_fail++; $display("FAIL n64_commit: ack %b strap %h exp 1 %h", c_prog_ack, c_strap, DEF64);
        end
        for (int i = 0; i < 6; i++) begin
            sdi = 1'($urandom_range(0, 1));
            step();
        end
        sdi_vld = 1'b0;
        n_checks++;
        if (c_strap !== data || c_busy !== 1'b0 || c_prog_ack !== 1'b0) begin
            n_fail++; $display("FAIL n64_strap: strap %h busy %b ack %b exp %h 0 0", c_strap, c_busy, c_prog_ack, data);
        end
        prog_req = 1'b0;
        step();
        while (sdo_exp.size() != 0) begin
            e = sdo_exp.pop_front();
            o = sdo_obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL n64_sdo: got %b exp %b", o, e); end
        end
    endtask

    initial begin
        rst      = 1'b1;
        prog_req = 1'b0;
        sdi      = 1'b0;
        sdi_vld  = 1'b0;
        lock     = 1'b0;
        test_reset();
        test_program();
        test_abort();
        test_lock();
        test_reset_mid_shift();
        test_n1();
        test_n64();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
